o_row_writer: RTL and testbench

- Downstream neighbour of the vector division stage. Accepts one normalized output row (O_VECTOR_T, VEC_LEN elements) per handshake.
- Buffers the row and serializes it as LANES-element beats onto the output-memory write port, generating addresses.
- Counts rows per tile and pulses tile_done after NUM_ROWS rows have been fully written.

---
 rtl/o_row_writer_pkg.sv | 30 +++
 rtl/o_row_beat_mux.sv | 18 +
 rtl/o_row_writer.sv | 134 +++++++++++++
 tb/tb_o_row_writer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/o_row_writer_pkg.sv
// Shared types for the O-row writer: full output row and one LANES-wide write beat.
// Latency: n/a (types only).
// Backpressure: n/a.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 8
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 16
`endif

package o_row_writer_pkg;

    localparam int O_VEC_LEN = `MAX_EMBEDDING_DIM;
    localparam int O_DATA_W  = `INTEGER_WIDTH;
    localparam int O_LANES   = 4;

    typedef logic [O_VEC_LEN-1:0][O_DATA_W-1:0] O_VECTOR_T;
    typedef logic [O_LANES-1:0][O_DATA_W-1:0]   O_BEAT_T;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } o_wr_state_e;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/o_row_beat_mux.sv
// Selects beat beat_sel of a buffered row; element beat_sel*LANES lands in the low lanes.
// Latency: combinational.
// Backpressure: none; the caller holds beat_sel and the row while a beat stalls.
module o_row_beat_mux #(
    parameter int VEC_LEN    = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int BW         = 1
) (
    input  logic [VEC_LEN/LANES-1:0][LANES*DATA_WIDTH-1:0] row,
    input  logic [BW-1:0]                                  beat_sel,
    output logic [LANES*DATA_WIDTH-1:0]                    beat_dat
);

    // Viewing the row as BEATS packed beats makes element order fall out of the bit layout.
    assign beat_dat = row[beat_sel];

endmodule

// File: rtl/o_row_writer.sv
// Buffers one O row and streams it as LANES-wide beats with addresses; pulses tile_done per NUM_ROWS rows.
// Latency: first beat the cycle after acceptance, BEATS cycles per row, zero bubble between rows.
// Backpressure: beats hold while rdy_in is low; rdy_out only on idle or last-beat transfer. Macro AURA_O_WRITER_PERF_EN adds stall_cycles.
module o_row_writer
    import o_row_writer_pkg::*;
#(
    parameter int VEC_LEN    = O_VEC_LEN,
    parameter int DATA_WIDTH = O_DATA_W,
    parameter int LANES      = O_LANES,
    parameter int NUM_ROWS   = 64,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vld_in,
    output logic                        rdy_out,
    input  O_VECTOR_T                   vec_in,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    output logic                        vld_out,
    input  logic                        rdy_in,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic [LANES*DATA_WIDTH-1:0] wr_data,
    output logic                        tile_done
`ifdef AURA_O_WRITER_PERF_EN
    ,
    output logic [31:0]                 stall_cycles
`endif
);

    localparam int BEATS = VEC_LEN / LANES;
    localparam int BW    = cnt_width(BEATS);
    localparam int RW    = cnt_width(NUM_ROWS);
    localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);
    localparam logic [RW-1:0]         LAST_ROW  = RW'(NUM_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] BEATS_A   = ADDR_WIDTH'(BEATS);

    if (VEC_LEN % LANES != 0) begin : g_bad_lanes
        $error("o_row_writer: VEC_LEN must be a multiple of LANES");
    end
    if (VEC_LEN * DATA_WIDTH != $bits(O_VECTOR_T)) begin : g_bad_vec
        $error("o_row_writer: VEC_LEN*DATA_WIDTH must match O_VECTOR_T");
    end

    o_wr_state_e                          state_q, state_d;
    logic [BW-1:0]                        beat_cnt_q;
    logic [RW-1:0]                        row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0]                tile_base_q;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0]   row_buf_q;
    logic                                 last_beat, xfer, last_xfer, accept;

    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign xfer      = vld_out && rdy_in;
    assign last_xfer = xfer && last_beat;
    assign accept    = vld_in && rdy_out;

    always_comb begin
        state_d = state_q;
        rdy_out = 1'b0;
        vld_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy_out = 1'b1;
                if (vld_in) state_d = ST_SEND;
            end
            ST_SEND: begin
                vld_out = 1'b1;
                if (rdy_in && last_beat) begin
                    rdy_out = 1'b1;
                    state_d = vld_in ? ST_SEND : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // A row accepted on the last-beat cycle belongs to the post-increment row index.
    always_comb begin
        row_cnt_d = row_cnt_q;
        if (last_xfer) row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            row_cnt_q   <= '0;
            tile_base_q <= '0;
            row_buf_q   <= '0;
            tile_done   <= 1'b0;
        end else begin
            row_cnt_q <= row_cnt_d;
            tile_done <= last_xfer && (row_cnt_q == LAST_ROW);
            if (accept) begin
                row_buf_q  <= vec_in;
                beat_cnt_q <= '0;
                if (row_cnt_d == '0) tile_base_q <= base_addr;
            end else if (last_xfer) begin
                beat_cnt_q <= '0;
            end else if (xfer) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign wr_addr = tile_base_q + ADDR_WIDTH'(row_cnt_q) * BEATS_A + ADDR_WIDTH'(beat_cnt_q);

    o_row_beat_mux #(
        .VEC_LEN    (VEC_LEN),
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .BW         (BW)
    ) u_beat_mux (
        .row      (row_buf_q),
        .beat_sel (beat_cnt_q),
        .beat_dat (wr_data)
    );

`ifdef AURA_O_WRITER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (accept && (row_cnt_d == '0)) begin
            stall_cycles <= '0;
        end else if (vld_out && !rdy_in && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_o_row_writer.sv
// Directed bench for o_row_writer (VEC_LEN=8, LANES=4, NUM_ROWS=3) with a beat-queue reference model.
module tb_o_row_writer;
    import o_row_writer_pkg::*;

    localparam int VL = 8, DW = 16, LN = 4, NR = 3, AW = 16, BT = VL / LN;

    logic clk = 1'b0, rst = 1'b1, vld_in = 1'b0, rdy_in = 1'b1;
    logic rdy_out, vld_out, tile_done;
    O_VECTOR_T vec_in = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] wr_addr;
    logic [LN*DW-1:0] wr_data;
`ifdef AURA_O_WRITER_PERF_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    o_row_writer #(
        .VEC_LEN(VL), .DATA_WIDTH(DW), .LANES(LN), .NUM_ROWS(NR), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .vec_in(vec_in),
        .base_addr(base_addr), .vld_out(vld_out), .rdy_in(rdy_in), .wr_addr(wr_addr),
        .wr_data(wr_data), .tile_done(tile_done)
`ifdef AURA_O_WRITER_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [LN*DW-1:0] data;
        logic             last;
        logic [7:0]       idx;
    } beat_t;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, stall_seen = 0, macc = 0;
    bit mon_en = 0;
    beat_t q[$];
    int beat_cyc[$];
    logic [AW-1:0] beat_adr[$];
    logic [LN*DW-1:0] beat_dat[$];
    int done_cyc[$];
    logic [AW-1:0] mbase = '0;
    logic exp_done = 1'b0, prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [LN*DW-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an accepted row becomes BEATS queued beats with spec-derived addresses.
    always @(negedge clk) begin
        beat_t e;
        logic exp_rdy, nd;
        cyc++;
        if (!mon_en) begin
        end else if (rst) begin
            q.delete();
            macc = 0;
            exp_done = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_rdy = (q.size() == 0) || (q.size() == 1 && rdy_in);
            check("vld_out", vld_out, q.size() != 0);
            check("rdy_out", rdy_out, exp_rdy);
            check("tile_done", tile_done, exp_done);
            if (tile_done === 1'b1) done_cyc.push_back(cyc);
            if (prev_stall) begin
                check("hold_vld", vld_out, 1'b1);
                check("hold_addr", wr_addr, prev_addr);
                check("hold_data", wr_data, prev_data);
            end
            nd = 1'b0;
            if (vld_out === 1'b1 && q.size() != 0) begin
                check("wr_addr", wr_addr, q[0].addr);
                check("wr_data", wr_data, q[0].data);
                if (rdy_in) begin
                    e = q.pop_front();
                    beat_cyc.push_back(cyc);
                    beat_adr.push_back(wr_addr);
                    beat_dat.push_back(wr_data);
                    if (e.last && e.idx == 8'(NR - 1)) nd = 1'b1;
                end
            end
            if (vld_in && rdy_out === 1'b1) begin
                if (macc == 0) mbase = base_addr;
                for (int b = 0; b < BT; b++) begin
                    e.addr = mbase + AW'(macc * BT + b);
                    for (int l = 0; l < LN; l++) e.data[l*DW +: DW] = vec_in[b*LN + l];
                    e.last = (b == BT - 1);
                    e.idx  = 8'(macc);
                    q.push_back(e);
                end
                macc = (macc + 1) % NR;
            end
            if (vld_out === 1'b1 && !rdy_in) stall_seen++;
            prev_stall = (vld_out === 1'b1) && !rdy_in;
            prev_addr = wr_addr;
            prev_data = wr_data;
            exp_done = nd;
        end
    end

    function automatic O_VECTOR_T mk_row(input int start);
        O_VECTOR_T r;
        for (int i = 0; i < VL; i++) r[i] = DW'(start + i);
        return r;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        check("rst_vld_out", vld_out, 1'b0);
        check("rst_rdy_out", rdy_out, 1'b1);
        check("rst_tile_done", tile_done, 1'b0);
        check("rst_wr_addr", wr_addr, 16'h0000);
        check("rst_wr_data", wr_data, 64'h0);
        @(posedge clk); #1;
    endtask

    task automatic offer_row(input O_VECTOR_T v, input logic [AW-1:0] b);
        bit ok = 0;
        vld_in = 1'b1; vec_in = v; base_addr = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rdy_out === 1'b1) ok = 1;
        end
        @(posedge clk); #1;
        vld_in = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL offer_row: row not accepted within 100 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (vld_out !== 1'b0 && n < 200);
        if (n >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: vld_out still high after 200 cycles");
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int k, d;
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d;
        do_reset();

        // Single row 1..8 at 0x100
        k = beat_cyc.size(); d = done_cyc.size();
        offer_row(mk_row(1), 16'h0100);
        wait_idle();
        check("t1_nbeats", beat_cyc.size() - k, 2);
        check("t1_addr0", beat_adr[k], 16'h0100);
        check("t1_data0", beat_dat[k], 64'h0004_0003_0002_0001);
        check("t1_addr1", beat_adr[k+1], 16'h0101);
        check("t1_data1", beat_dat[k+1], 64'h0008_0007_0006_0005);
        check("t1_consec", beat_cyc[k+1] - beat_cyc[k], 1);
        check("t1_no_done", done_cyc.size() - d, 0);
        check("t1_rdy_out", rdy_out, 1'b1);

        // Three back-to-back rows complete a tile
        do_reset();
        k = beat_cyc.size(); d = done_cyc.size();
        offer_row(mk_row(1), 16'h0100);
        offer_row(mk_row(11), 16'h0100);
        offer_row(mk_row(21), 16'h0100);
        wait_idle();
        check("t2_nbeats", beat_cyc.size() - k, 6);
        for (int i = 0; i < 6; i++) begin
            check("t2_addr", beat_adr[k+i], 64'(16'h0100 + i));
            check("t2_consec", beat_cyc[k+i] - beat_cyc[k], i);
        end
        check("t2_row2_beat1", beat_dat[k+5], 64'h001C_001B_001A_0019);
        check("t2_done_count", done_cyc.size() - d, 1);
        check("t2_done_cycle", done_cyc[d], beat_cyc[k+5] + 1);

        // Next tile picks up a fresh base; mid-tile base changes are ignored
        k = beat_cyc.size();
        offer_row(mk_row(31), 16'h0200);
        offer_row(mk_row(41), 16'h0300);
        wait_idle();
        check("t4_addr0", beat_adr[k], 16'h0200);
        check("t4_addr1", beat_adr[k+1], 16'h0201);
        check("t4_addr2", beat_adr[k+2], 16'h0202);
        check("t4_addr3", beat_adr[k+3], 16'h0203);

        // Five stalled cycles on beat 0
        do_reset();
        k = beat_cyc.size();
        rdy_in = 1'b0;
        stall_seen = 0;
        offer_row(mk_row(1), 16'h0100);
        repeat (5) @(posedge clk);
        #1;
`ifdef AURA_O_WRITER_PERF_EN
        check("t3_stall_cycles", stall_cycles, 32'd5);
`endif
        rdy_in = 1'b1;
        wait_idle();
        check("t3_stall_seen", stall_seen, 5);
        check("t3_addr0", beat_adr[k], 16'h0100);
        check("t3_data0", beat_dat[k], 64'h0004_0003_0002_0001);
`ifdef AURA_O_WRITER_PERF_EN
        check("t3_stall_final", stall_cycles, 32'd5);
`endif

        // Reset during beat 1 of row 1 aborts the row
        do_reset();
        k = beat_cyc.size(); d = done_cyc.size();
        offer_row(mk_row(1), 16'h0100);
        offer_row(mk_row(11), 16'h0180);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_vld_out", vld_out, 1'b0);
        check("t5_rdy_out", rdy_out, 1'b1);
        check("t5_tile_done", tile_done, 1'b0);
        check("t5_beats_before", beat_cyc.size() - k, 3);
        @(posedge clk); #1;
        offer_row(mk_row(51), 16'h0400);
        wait_idle();
        check("t5_new_addr0", beat_adr[k+3], 16'h0400);
        check("t5_new_addr1", beat_adr[k+4], 16'h0401);
        check("t5_no_done", done_cyc.size() - d, 0);

        // Address wrap at the top of the address space
        do_reset();
        k = beat_cyc.size();
        offer_row(mk_row(61), 16'hFFFF);
        wait_idle();
        check("t6_addr0", beat_adr[k], 16'hFFFF);
        check("t6_addr1", beat_adr[k+1], 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
